// File: rtl/registro_pkg.sv
// Shared definitions for the shift-register sequencer: register modes, FSM states, buffer width.
// The buffer always carries a rotate bit; it stays 0 unless CONTROL_REGISTRO_ROTATE_EN is defined.
package registro_pkg;

   localparam logic [1:0] MODO_SHIFT = 2'b00;
   localparam logic [1:0] MODO_ROT   = 2'b01;
   localparam logic [1:0] MODO_LOAD  = 2'b10;
   localparam logic [1:0] MODO_HOLD  = 2'b11;

   // {word[3:0], dir, fill, rotate}
   localparam int ENTRADA_W = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      DONE_ST = 2'd3
   } estado_t;

endpackage

// File: rtl/control_registro_4_buffer_entrada.sv
// buffer_entrada: one-entry input buffer, ready while empty and not cleared, synchronous clear.
// A pushed entry is visible on q from the next cycle until popped.
module buffer_entrada #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] dato,
   input  logic         valid,
   output logic         ready,
   input  logic         pop,
   output logic [W-1:0] q,
   output logic         full
);

   assign ready = !full && !clr;

   always_ff @(posedge clk) begin
      if (clr) begin
         full <= 1'b0;
         q    <= '0;
      end else if (valid && ready) begin
         full <= 1'b1;
         q    <= dato;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/control_registro_4.sv
// control_registro_4: buffers 4-bit words and drives a 4-bit shift register to load, then shift each out.
// Optional macro CONTROL_REGISTRO_ROTATE_EN adds ROTAR_IN, selecting rotate mode for a word.
module control_registro_4
   import registro_pkg::*;
#(
   parameter int N_SHIFT = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] DATO_IN,
   input  logic       DIR_IN,
   input  logic       RELLENO_IN,
`ifdef CONTROL_REGISTRO_ROTATE_EN
   input  logic       ROTAR_IN,
`endif
   input  logic       DATO_VALID,
   output logic       DATO_READY,
   output logic       ENB,
   output logic [1:0] MODO,
   output logic       DIR,
   output logic [3:0] D,
   output logic       S_IN,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [3:0] ULTIMO = 4'(N_SHIFT - 1);

   logic [ENTRADA_W-1:0] entrada;
   logic [ENTRADA_W-1:0] salida;
   logic                 buf_full;
   logic                 pop;
   estado_t              estado;
   logic [3:0]           cnt;
   logic [3:0]           word;
   logic                 dir_w;
   logic                 fill_w;
   logic                 rot_w;

`ifdef CONTROL_REGISTRO_ROTATE_EN
   assign entrada = {DATO_IN, DIR_IN, RELLENO_IN, ROTAR_IN};
`else
   assign entrada = {DATO_IN, DIR_IN, RELLENO_IN, 1'b0};
`endif

   // The next word may be taken from IDLE or straight out of DONE_ST.
   assign pop = buf_full && (estado == IDLE || estado == DONE_ST);

   buffer_entrada #(.W(ENTRADA_W)) u_buffer (
      .clk   (CLK),
      .clr   (RESET),
      .dato  (entrada),
      .valid (DATO_VALID),
      .ready (DATO_READY),
      .pop   (pop),
      .q     (salida),
      .full  (buf_full)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         estado <= IDLE;
         cnt    <= 4'd0;
         word   <= 4'd0;
         dir_w  <= 1'b0;
         fill_w <= 1'b0;
         rot_w  <= 1'b0;
      end else begin
         case (estado)
            IDLE, DONE_ST: begin
               if (buf_full) begin
                  estado <= LOAD;
                  word   <= salida[6:3];
                  dir_w  <= salida[2];
                  fill_w <= salida[1];
                  rot_w  <= salida[0];
               end else begin
                  estado <= IDLE;
               end
            end
            LOAD: begin
               estado <= SHIFT;
               cnt    <= 4'd0;
            end
            SHIFT: begin
               if (cnt == ULTIMO) begin
                  estado <= DONE_ST;
                  cnt    <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

   // DIR keeps the last word's direction outside LOAD/SHIFT.
   always_comb begin
      ENB  = 1'b0;
      MODO = MODO_HOLD;
      DIR  = dir_w;
      D    = 4'd0;
      S_IN = 1'b0;
      BUSY = 1'b0;
      DONE = 1'b0;
      case (estado)
         LOAD: begin
            ENB  = 1'b1;
            MODO = MODO_LOAD;
            D    = word;
            BUSY = 1'b1;
         end
         SHIFT: begin
            ENB  = 1'b1;
            MODO = rot_w ? MODO_ROT : MODO_SHIFT;
            D    = word;
            S_IN = fill_w && !rot_w;
            BUSY = 1'b1;
         end
         DONE_ST: DONE = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_registro_4.sv
// Bench for control_registro_4: a job-schedule model predicts every output each cycle.
// Define CONTROL_REGISTRO_ROTATE_EN for both bench and RTL to exercise rotate words.
module tb_control_registro_4;

   localparam int N = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] DATO_IN = 4'd0;
   logic       DIR_IN = 1'b0;
   logic       RELLENO_IN = 1'b0;
   logic       ROTAR_IN = 1'b0;
   logic       DATO_VALID = 1'b0;
   logic       DATO_READY, ENB, DIR, S_IN, BUSY, DONE;
   logic [1:0] MODO;
   logic [3:0] D;

   int n_chk = 0;
   int n_fail = 0;

   control_registro_4 #(.N_SHIFT(N)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DATO_IN    (DATO_IN),
      .DIR_IN     (DIR_IN),
      .RELLENO_IN (RELLENO_IN),
`ifdef CONTROL_REGISTRO_ROTATE_EN
      .ROTAR_IN   (ROTAR_IN),
`endif
      .DATO_VALID (DATO_VALID),
      .DATO_READY (DATO_READY),
      .ENB        (ENB),
      .MODO       (MODO),
      .DIR        (DIR),
      .D          (D),
      .S_IN       (S_IN),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // Model: every accepted word becomes a job with its accept edge and its load edge.
   typedef struct {
      int         ta;
      int         le;
      logic [3:0] w;
      logic       dr;
      logic       fl;
      logic       rt;
   } job_t;

   job_t jobs[$];
   int   e = 0;
   int   prev_le = -100;
   logic acepto = 1'b0;
   int   ult_ta = 0;
   int   ult_le = 0;

   function automatic logic buf_full(int ee);
      for (int i = 0; i < jobs.size(); i++)
         if (jobs[i].ta <= ee && ee < jobs[i].le) return 1'b1;
      return 1'b0;
   endfunction

   // {READY, ENB, MODO, DIR, D, S_IN, BUSY, DONE}
   function automatic logic [11:0] esperado();
      logic       rdy, enb, dr, si, bz, dn;
      logic [1:0] md;
      logic [3:0] dd;
      rdy = !RESET && !buf_full(e);
      enb = 0; md = 2'b11; dr = 0; dd = 0; si = 0; bz = 0; dn = 0;
      for (int i = 0; i < jobs.size(); i++) begin
         if (jobs[i].le <= e) dr = jobs[i].dr;
         if (e == jobs[i].le) begin
            enb = 1; md = 2'b10; dd = jobs[i].w; bz = 1;
         end else if (e > jobs[i].le && e <= jobs[i].le + N) begin
            enb = 1; md = jobs[i].rt ? 2'b01 : 2'b00; dd = jobs[i].w;
            si = jobs[i].rt ? 1'b0 : jobs[i].fl; bz = 1;
         end else if (e == jobs[i].le + N + 1) begin
            dn = 1;
         end
      end
      return {rdy, enb, md, dr, dd, si, bz, dn};
   endfunction

   function automatic logic [11:0] observado();
      return {DATO_READY, ENB, MODO, DIR, D, S_IN, BUSY, DONE};
   endfunction

   task automatic tick();
      logic acc;
      job_t j;
      acc = DATO_VALID && !RESET && !buf_full(e);
      j.w = DATO_IN; j.dr = DIR_IN; j.fl = RELLENO_IN;
`ifdef CONTROL_REGISTRO_ROTATE_EN
      j.rt = ROTAR_IN;
`else
      j.rt = 1'b0;
`endif
      @(posedge CLK);
      e++;
      acepto = 1'b0;
      if (RESET) begin
         jobs.delete();
         prev_le = -100;
      end else if (acc) begin
         j.ta = e;
         j.le = (e + 1 > prev_le + N + 2) ? e + 1 : prev_le + N + 2;
         prev_le = j.le;
         jobs.push_back(j);
         acepto = 1'b1;
         ult_ta = e;
         ult_le = j.le;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic rnd, input logic [3:0] w);
      DATO_VALID = v;
      DATO_IN    = rnd ? 4'($urandom) : w;
      DIR_IN     = 1'($urandom);
      RELLENO_IN = 1'($urandom);
`ifdef CONTROL_REGISTRO_ROTATE_EN
      ROTAR_IN   = rnd ? 1'($urandom) : 1'b0;
`endif
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      drive(1'b1, 1'b1, 4'd0);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b1, 4'd0);
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", observado(), esperado());
         end
         n_chk++;
         if (observado() !== 12'h300) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 300", observado());
         end
         tick();
      end
   endtask

   task automatic test_single();
      int t0, nbusy, off_done;
      RESET = 1'b0;
      drive(1'b1, 1'b0, 4'b1011);
      DIR_IN = 1'b0; RELLENO_IN = 1'b1;
      n_chk++;
      if (DATO_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b expected 1", DATO_READY);
      end
      tick();
      t0 = e; nbusy = 0; off_done = -1;
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, 1'b1, 4'd0);
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL single_model cyc %0d: got %h expected %h", e - t0, observado(), esperado());
         end
         if (e == t0 + 1) begin
            n_chk++;
            if (MODO !== 2'b10 || D !== 4'b1011) begin
               n_fail++;
               $display("FAIL single_load: got MODO=%b D=%b expected 10/1011", MODO, D);
            end
         end
         if (BUSY === 1'b1) nbusy++;
         if (DONE === 1'b1) off_done = e - t0;
         tick();
      end
      n_chk++;
      if (nbusy !== 5) begin
         n_fail++;
         $display("FAIL single_busy_len: got %0d expected 5", nbusy);
      end
      n_chk++;
      if (off_done !== 6) begin
         n_fail++;
         $display("FAIL single_done_time: got %0d expected 6", off_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ws[2];
      int idx, nd, ta2;
      int dones[4];
      ws[0] = 4'h3; ws[1] = 4'hC;
      idx = 0; nd = 0; ta2 = 0;
      for (int c = 0; c < 20; c++) begin
         drive(idx < 2, 1'b0, (idx < 2) ? ws[idx] : 4'd0);
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL b2b_model: got %h expected %h", observado(), esperado());
         end
         if (DONE === 1'b1 && nd < 4) begin dones[nd] = e; nd++; end
         tick();
         if (acepto) begin
            if (idx == 1) ta2 = e;
            idx++;
         end
      end
      n_chk++;
      if (nd !== 2 || dones[1] - dones[0] !== 6) begin
         n_fail++;
         $display("FAIL b2b_done_spacing: got count %0d gap %0d expected 2 and 6", nd, dones[1] - dones[0]);
      end
      n_chk++;
      if (idx !== 2 || ta2 >= dones[0]) begin
         n_fail++;
         $display("FAIL b2b_second_accept: got accepted %0d at %0d expected 2 before %0d", idx, ta2, dones[0]);
      end
   endtask

   task automatic test_backpressure();
      int idx;
      int acc[3];
      idx = 0;
      for (int c = 0; c < 26; c++) begin
         drive(idx < 3, 1'b1, 4'd0);
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL bp_model: got %h expected %h", observado(), esperado());
         end
         tick();
         if (acepto && idx < 3) begin acc[idx] = e; idx++; end
      end
      n_chk++;
      if (idx !== 3 || acc[1] - acc[0] !== 2 || acc[2] - acc[0] !== 8) begin
         n_fail++;
         $display("FAIL bp_accept_times: got n=%0d +%0d +%0d expected 3 +2 +8", idx, acc[1] - acc[0], acc[2] - acc[0]);
      end
   endtask

   task automatic test_reset_mid();
      int idx, le_a, nbusy_after, ndone;
      idx = 0; le_a = -100; nbusy_after = 0; ndone = 0;
      for (int c = 0; c < 18; c++) begin
         drive(idx < 2, 1'b1, 4'd0);
         RESET = (e == le_a + 2);
         #1;
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL rmid_model: got %h expected %h", observado(), esperado());
         end
         if (e == le_a + 3) begin
            n_chk++;
            if (observado() !== 12'hB00) begin
               n_fail++;
               $display("FAIL rmid_after_reset: got %h expected b00", observado());
            end
         end
         if (DONE === 1'b1) ndone++;
         if (le_a > 0 && e > le_a + 2 && BUSY === 1'b1) nbusy_after++;
         tick();
         if (acepto) begin
            if (idx == 0) le_a = ult_le;
            idx++;
         end
      end
      RESET = 1'b0;
      n_chk++;
      if (ndone !== 0 || nbusy_after !== 0 || idx !== 2) begin
         n_fail++;
         $display("FAIL rmid_discard: got done=%0d busy=%0d accepted=%0d expected 0 0 2", ndone, nbusy_after, idx);
      end
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 1'b1, 4'd0);
         n_chk++;
         if (ENB !== 1'b0 || MODO !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_hold: got ENB=%b MODO=%b expected 0/11", ENB, MODO);
         end
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL idle_model: got %h expected %h", observado(), esperado());
         end
         tick();
      end
   endtask

`ifdef CONTROL_REGISTRO_ROTATE_EN
   task automatic test_rotate();
      int le;
      le = -100;
      for (int c = 0; c < 10; c++) begin
         drive(c == 0, 1'b0, 4'b1001);
         if (c == 0) begin ROTAR_IN = 1'b1; RELLENO_IN = 1'b1; end
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL rot_model: got %h expected %h", observado(), esperado());
         end
         if (e > le && e <= le + N) begin
            n_chk++;
            if (MODO !== 2'b01 || S_IN !== 1'b0) begin
               n_fail++;
               $display("FAIL rot_shift: got MODO=%b S_IN=%b expected 01/0", MODO, S_IN);
            end
         end
         tick();
         if (acepto) le = ult_le;
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 2) != 0, 1'b1, 4'd0);
         RESET = ($urandom_range(0, 59) == 0);
         #1;
         n_chk++;
         if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: got %h expected %h", c, observado(), esperado());
         end
         tick();
      end
      RESET = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_idle();
      test_backpressure();
      test_idle();
      test_reset_mid();
      test_idle();
`ifdef CONTROL_REGISTRO_ROTATE_EN
      test_rotate();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
